// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared geometry, latency and attribute layout for the text display stage
package text_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 25;
  localparam int CELL_W   = 8;
  localparam int CELL_H   = 16;
  localparam int ACT_W    = 640;
  localparam int ACT_H    = 400;
  localparam int PIPE     = 4;
  localparam int H_LAST   = 799;
  localparam int ADDR_MAX = COLS * ROWS - 1;

  localparam int ATTR_B   = 0;
  localparam int ATTR_R   = 1;
  localparam int ATTR_G   = 2;
  localparam int ATTR_REV = 3;

  typedef struct packed {
    logic rev;
    logic g;
    logic r;
    logic b;
  } attr_t;

  function automatic attr_t attr_decode(input logic [7:0] a);
    return attr_t'(a[ATTR_REV:ATTR_B]);
  endfunction

  function automatic logic [3:0] chan(input logic on);
    return on ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/text_shifter.sv
// rtl/text_shifter.sv - 8-bit glyph shifter with reverse/cursor inversion and registered RGB output
module text_shifter
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       valid,
  input  attr_t      attr,
  input  logic [7:0] glyph,
  input  logic       cursor_inv,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  logic [7:0] sh_q, sh_d;
  logic [2:0] en_q, en_d;
  logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0] pat;
  logic [2:0] en_now;
  logic       pix;

  // Blank cells load an empty pattern with all channels disabled, so a
  // reverse attribute can never light pixels outside the active area.
  always_comb begin
    pat    = glyph ^ {8{attr.rev}} ^ {8{cursor_inv}};
    sh_d   = {sh_q[6:0], 1'b0};
    en_d   = en_q;
    pix    = sh_q[7];
    en_now = en_q;
    if (load) begin
      pix    = valid & pat[7];
      sh_d   = valid ? {pat[6:0], 1'b0} : 8'h00;
      en_d   = valid ? {attr.g, attr.r, attr.b} : 3'b000;
      en_now = en_d;
    end
    r_d = chan(pix & en_now[1]);
    g_d = chan(pix & en_now[2]);
    b_d = chan(pix & en_now[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
      en_q <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      sh_q <= sh_d;
      en_q <= en_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: rtl/text_vdisp.sv
// rtl/text_vdisp.sv - 80x25 text display: VRAM walk, font fetch, pixel pipeline, sync delay
// Optional underline cursor with blink counter when TEXT_CURSOR_EN is defined.
module text_vdisp
  import text_pkg::*;
#(
  parameter int VOFS = 40,
  parameter int PIPE = text_pkg::PIPE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  H_CNT,
  input  logic [9:0]  V_CNT,
  input  logic        HS_IN,
  input  logic        VS_IN,
  output logic [10:0] VRAM_ADDR,
  input  logic [15:0] VRAM_DATA,
  output logic [10:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  input  logic [6:0]  CUR_X,
  input  logic [4:0]  CUR_Y,
  output logic        HS,
  output logic        VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam logic [9:0] V_FIRST = 10'(VOFS);
  localparam logic [9:0] V_END   = 10'(VOFS + ACT_H);
  localparam logic [9:0] V_PRE   = 10'(VOFS - 1);

  logic [9:0]  rel;
  logic        v_act, active, cell_start, fetch, line_end, line_clr, line_inc;
  logic        cur_hit;
  logic [10:0] line_base_q, line_base_d, vram_addr_q, vram_addr_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic        s1_start_q, s1_start_d, s1_valid_q, s1_valid_d, s1_cur_q, s1_cur_d;
  logic [2:0]  s1_grow_q, s1_grow_d;
  logic        s2_start_q, s2_start_d, s2_valid_q, s2_valid_d, s2_cur_q, s2_cur_d;
  attr_t       s2_attr_q, s2_attr_d, s3_attr_q, s3_attr_d;
  logic        s3_start_q, s3_start_d, s3_valid_q, s3_valid_d, s3_cur_q, s3_cur_d;
  logic [7:0]  s3_glyph_q, s3_glyph_d;
  logic [PIPE-1:0] hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
  logic        data_unused;

  assign rel        = V_CNT - V_FIRST;
  assign v_act      = (V_CNT >= V_FIRST) && (V_CNT < V_END);
  assign active     = v_act && (H_CNT < 10'(ACT_W));
  assign cell_start = (H_CNT[2:0] == 3'd0);
  assign fetch      = active && cell_start;
  assign line_end   = (H_CNT == 10'(H_LAST));
  assign line_clr   = line_end && (V_CNT == V_PRE);
  // Gating the step to active lines keeps line_base bounded during blanking.
  assign line_inc   = line_end && v_act && (rel[3:0] == 4'hF);

  always_comb begin
    line_base_d = line_base_q;
    if (line_clr)
      line_base_d = '0;
    else if (line_inc)
      line_base_d = line_base_q + 11'(COLS);
    vram_addr_d = fetch ? (line_base_q + {4'd0, H_CNT[9:3]}) : vram_addr_q;

    s1_start_d  = cell_start;
    s1_valid_d  = fetch;
    s1_grow_d   = rel[3:1];
    s1_cur_d    = cur_hit;

    font_addr_d = s1_valid_q ? {VRAM_DATA[7:0], s1_grow_q} : font_addr_q;
    s2_attr_d   = attr_decode(VRAM_DATA[15:8]);
    s2_start_d  = s1_start_q;
    s2_valid_d  = s1_valid_q;
    s2_cur_d    = s1_cur_q;

    s3_glyph_d  = FONT_DATA;
    s3_attr_d   = s2_attr_q;
    s3_start_d  = s2_start_q;
    s3_valid_d  = s2_valid_q;
    s3_cur_d    = s2_cur_q;

    hs_dly_d    = {hs_dly_q[PIPE-2:0], HS_IN};
    vs_dly_d    = {vs_dly_q[PIPE-2:0], VS_IN};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      line_base_q <= '0;
      vram_addr_q <= '0;
      font_addr_q <= '0;
      s1_start_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_grow_q   <= '0;
      s1_cur_q    <= 1'b0;
      s2_start_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_attr_q   <= '0;
      s2_cur_q    <= 1'b0;
      s3_start_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_attr_q   <= '0;
      s3_cur_q    <= 1'b0;
      s3_glyph_q  <= '0;
      hs_dly_q    <= '1;
      vs_dly_q    <= '1;
    end else begin
      line_base_q <= line_base_d;
      vram_addr_q <= vram_addr_d;
      font_addr_q <= font_addr_d;
      s1_start_q  <= s1_start_d;
      s1_valid_q  <= s1_valid_d;
      s1_grow_q   <= s1_grow_d;
      s1_cur_q    <= s1_cur_d;
      s2_start_q  <= s2_start_d;
      s2_valid_q  <= s2_valid_d;
      s2_attr_q   <= s2_attr_d;
      s2_cur_q    <= s2_cur_d;
      s3_start_q  <= s3_start_d;
      s3_valid_q  <= s3_valid_d;
      s3_attr_q   <= s3_attr_d;
      s3_cur_q    <= s3_cur_d;
      s3_glyph_q  <= s3_glyph_d;
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_q, frame_d, row_q, row_d;
  logic       vs_prev_q, vs_prev_d;

  // Text row tracked alongside line_base so the cursor compare needs no divide.
  always_comb begin
    vs_prev_d = VS_IN;
    frame_d   = (vs_prev_q && !VS_IN) ? frame_q + 5'd1 : frame_q;
    row_d     = row_q;
    if (line_clr)
      row_d = '0;
    else if (line_inc)
      row_d = row_q + 5'd1;
    cur_hit = frame_q[4] && (H_CNT[9:3] == CUR_X) && (row_q == CUR_Y) && (rel[3:1] == 3'd7);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q   <= '0;
      row_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      frame_q   <= frame_d;
      row_q     <= row_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign data_unused = ^{VRAM_DATA[15:12], rel[9:4]};
`else
  assign cur_hit     = 1'b0;
  assign data_unused = ^{VRAM_DATA[15:12], rel[9:4], CUR_X, CUR_Y};
`endif

  text_shifter u_shifter (
    .clk        (CLK),
    .rst        (RST),
    .load       (s3_start_q),
    .valid      (s3_valid_q),
    .attr       (s3_attr_q),
    .glyph      (s3_glyph_q),
    .cursor_inv (s3_cur_q),
    .r          (VGA_R),
    .g          (VGA_G),
    .b          (VGA_B)
  );

  assign VRAM_ADDR = vram_addr_q;
  assign FONT_ADDR = font_addr_q;
  assign HS        = hs_dly_q[PIPE-1];
  assign VS        = vs_dly_q[PIPE-1];

endmodule

// File: tb/tb_text_vdisp.sv
// tb/tb_text_vdisp.sv - randomized self-checking bench for text_vdisp against a cell/glyph reference model
module tb_text_vdisp;
  import text_pkg::*;

  localparam int VOFS_TB = 40;
  localparam int CX = 5;
  localparam int CY = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  H_CNT = '0;
  logic [9:0]  V_CNT = '0;
  logic        HS_IN = 1'b1;
  logic        VS_IN = 1'b1;
  logic [10:0] VRAM_ADDR, FONT_ADDR;
  logic [15:0] VRAM_DATA;
  logic [7:0]  FONT_DATA;
  logic [6:0]  CUR_X = 7'(CX);
  logic [4:0]  CUR_Y = 5'(CY);
  logic        HS, VS;
  logic [3:0]  VGA_R, VGA_G, VGA_B;

  logic [15:0] vram [0:2047];
  logic [7:0]  font [0:2047];

  assign VRAM_DATA = vram[VRAM_ADDR];
  assign FONT_DATA = font[FONT_ADDR];

  text_vdisp #(.VOFS(VOFS_TB)) dut (
    .CLK(CLK), .RST(RST), .H_CNT(H_CNT), .V_CNT(V_CNT), .HS_IN(HS_IN), .VS_IN(VS_IN),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
    .CUR_X(CUR_X), .CUR_Y(CUR_Y), .HS(HS), .VS(VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #20 CLK = ~CLK;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        care;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   fcnt;
  bit   vs_prev, trust, addr_known;
  int   exp_addr;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected colour straight from the cell/glyph/attribute rules.
  function automatic logic [11:0] ref_pixel(input int v, input int h, input int fc);
    int          rel  = v - VOFS_TB;
    int          row  = rel / 16;
    int          line = rel % 16;
    int          col  = h / 8;
    logic [15:0] w    = vram[row * 80 + col];
    logic [7:0]  gl   = font[int'(w[7:0]) * 8 + line / 2];
    logic        lit  = gl[7 - h % 8] ^ w[11];
`ifdef TEXT_CURSOR_EN
    if (fc >= 16 && col == CX && row == CY && line >= 14) lit = !lit;
`endif
    return {(lit && w[9]) ? 4'hF : 4'h0, (lit && w[10]) ? 4'hF : 4'h0, (lit && w[8]) ? 4'hF : 4'h0};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    repeat (3) exp_q.push_back(exp_t'{hs: 1'b1, vs: 1'b1, care: 1'b1, rgb: 12'h0});
    fcnt = 0;
    vs_prev = 1'b1;
    trust = 1'b0;
    addr_known = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    RST = 1'b1;
    #1;
    check("rst_vram_addr", int'(VRAM_ADDR), 0);
    check("rst_font_addr", int'(FONT_ADDR), 0);
    check("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    check("rst_hs", int'(HS), 1);
    check("rst_vs", int'(VS), 1);
    repeat (n) @(posedge CLK);
    #1;
    check("rst_hold_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    check("rst_hold_hs", int'(HS), 1);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic tick(input int v, input int h);
    exp_t e;
    bit   act, fetch;
    H_CNT = 10'(h);
    V_CNT = 10'(v);
    HS_IN = !(h >= 656 && h < 752);
    VS_IN = !(v == 490 || v == 491);
    @(posedge CLK);
    #1;
    act   = (h < 640) && (v >= VOFS_TB) && (v < VOFS_TB + 400);
    fetch = act && (h % 8 == 0);
    e.hs   = HS_IN;
    e.vs   = VS_IN;
    e.care = !act || trust;
    e.rgb  = (act && trust) ? ref_pixel(v, h, fcnt) : 12'h0;
    exp_q.push_back(e);
    e = exp_q.pop_front();
    check("hs", int'(HS), int'(e.hs));
    check("vs", int'(VS), int'(e.vs));
    if (e.care) check("rgb", int'({VGA_R, VGA_G, VGA_B}), int'(e.rgb));
    check("addr_range", int'(VRAM_ADDR <= 11'(ADDR_MAX)), 1);
    if (fetch) begin
      addr_known = trust;
      exp_addr   = ((v - VOFS_TB) / CELL_H) * COLS + h / CELL_W;
    end
    if (addr_known) check("vram_addr", int'(VRAM_ADDR), exp_addr);
    if (vs_prev && !VS_IN) fcnt = (fcnt + 1) % 32;
    vs_prev = VS_IN;
    if (v == VOFS_TB - 1 && h == H_LAST) trust = 1'b1;
  endtask

  // Lines not of interest are shortened to their H=799 cycle so line_base still advances.
  task automatic run_frame(input bit rich, input bit inject, input int vr);
    for (int v = 0; v < 525; v++) begin
      if (rich && (v == 40 || v == 41 || v == 439 || v == 440 || v == vr || (inject && v == 200))) begin
        for (int h = 0; h < 800; h++) begin
          tick(v, h);
          if (inject && v == 200 && h == 299) reset_pulse(3);
        end
      end else if ((rich && v >= 56 && v <= 71) || v == 86 || v == 87) begin
        for (int h = 0; h < 64; h++) tick(v, h);
        for (int h = 640; h < 648; h++) tick(v, h);
        tick(v, H_LAST);
      end else begin
        tick(v, H_LAST);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    for (int r = 0; r < 8; r++) font[8'h20 * 8 + r] = 8'h00;
    font[8'h41 * 8] = 8'h18;
    vram[0]  = 16'h0741;
    vram[83] = 16'h0A20;
    vram[84] = 16'h0C20;
    vram[CY * 80 + CX] = 16'h0B41;

    @(posedge CLK);
    #1;
    reset_pulse(3);
    run_frame(1'b1, 1'b0, 42 + $urandom_range(0, 397));
    for (int f = 1; f < 34; f++) run_frame(1'b0, 1'b0, 0);
    run_frame(1'b1, 1'b1, 42 + $urandom_range(0, 397));
    run_frame(1'b1, 1'b0, 42 + $urandom_range(0, 397));
    run_frame(1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
